lfsr_seq_ctrl: RTL and testbench

- Sequencer that owns the control side of the 4-bit `lfsr` datapath: loads a seed, then either runs a programmed number of shifts or measures the sequence period (cycles until the register returns to the seed).
- Drives the `lfsr` A/select inputs and observes its O output.
- Sits between the lab top-level/host FSM and one `lfsr` instance; reports completion through a start/done handshake.

---
 rtl/lfsr_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
//   Control sequencer for a 4-bit `lfsr` datapath. It loads a seed into the
//   LFSR and then does one of two things:
//   - Count mode: runs a programmed number of shifts.
//   - Period mode: counts shifts until the register returns to the seed,
//     or until MAX_STEPS shifts have been made.
//   Completion is reported with a one-cycle `done` pulse.
//
//   Optional build macro: LFSR_SEQ_CTRL_PERIOD_CHECK_EN
//     When defined, a period-mode run that completes without timeout raises
//     period_ok if the measured period is 2^WIDTH-1 (maximal length).
//     When undefined, period_ok is tied low.
//
// Ports
//   CLK          system clock, posedge
//   reset        synchronous active-low reset
//   start        run request, accepted only while idle
//   mode         0 = count mode, 1 = period mode
//   seed         seed value, captured on accept
//   steps        shift count for count mode, captured on accept
//   busy         high whenever the sequencer is not idle
//   done         one-cycle completion pulse
//   result_cnt   shifts performed; held until the next accept
//   timeout      period mode reached MAX_STEPS; held
//   err_seed     run rejected because seed was zero; held
//   period_ok    maximal-length indication (optional feature)
//   lfsr_A       LFSR parallel-load value
//   lfsr_select  LFSR control: 0 = load lfsr_A, 1 = shift
//   lfsr_O       LFSR registered state
module lfsr_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 5,
  parameter int MAX_STEPS = 20
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result_cnt,
  output logic             timeout,
  output logic             err_seed,
  output logic             period_ok,
  output logic [WIDTH-1:0] lfsr_A,
  output logic             lfsr_select,
  input  logic [WIDTH-1:0] lfsr_O
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;

  // Stop conditions evaluated in SHIFT.
  // cnt_q == 0 is excluded from seed_hit, because at that point lfsr_O still
  // holds the freshly loaded seed.
  logic seed_hit, to_hit, stop, accept, finish;

  assign seed_hit = (cnt_q != '0) && (lfsr_O == seed_q);
  assign to_hit   = (cnt_q == CNT_W'(MAX_STEPS));
  assign stop     = mode_q ? (seed_hit || to_hit) : (cnt_q == steps_q);
  assign accept   = (state_q == IDLE) && start;
  assign finish   = (state_q == SHIFT) && stop;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;
    steps_d     = steps_q;
    mode_d      = mode_q;
    result_d    = result_q;
    timeout_d   = timeout_q;
    err_d       = err_q;

    // The lfsr has no hold input. Reloading its own output is what keeps
    // the value stable in every non-shifting cycle.
    lfsr_select = 1'b0;
    lfsr_A      = lfsr_O;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          seed_d    = seed;
          steps_d   = steps;
          mode_d    = mode;
          result_d  = '0;
          timeout_d = 1'b0;
          err_d     = 1'b0;
          if (seed == '0) begin
            // An all-zero seed locks the LFSR, so the run is rejected
            // without touching the datapath.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        lfsr_A  = seed_q;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (stop) begin
          result_d  = cnt_q;
          // A seed match wins over a coincident timeout.
          timeout_d = mode_q && !seed_hit && to_hit;
          state_d   = DONE;
        end else begin
          lfsr_select = 1'b1;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Freeze the datapath during reset. An aborted run then leaves the
    // LFSR exactly where it stood.
    if (!reset) begin
      lfsr_select = 1'b0;
      lfsr_A      = lfsr_O;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      seed_q    <= '0;
      steps_q   <= '0;
      mode_q    <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      steps_q   <= steps_d;
      mode_q    <= mode_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

`ifdef LFSR_SEQ_CTRL_PERIOD_CHECK_EN
  logic pok_q, pok_d;

  always_comb begin
    pok_d = pok_q;
    if (accept) begin
      pok_d = 1'b0;
    end else if (finish) begin
      pok_d = mode_q && seed_hit && (cnt_q == CNT_W'((1 << WIDTH) - 1));
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) pok_q <= 1'b0;
    else        pok_q <= pok_d;
  end

  assign period_ok = pok_q;
`else
  assign period_ok = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign result_cnt = result_q;
  assign timeout    = timeout_q;
  assign err_seed   = err_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl.
//   Two instances share the same stimulus:
//     u0: MAX_STEPS = 20
//     u1: MAX_STEPS = 10, which exercises timeout
//   Each instance drives its own behavioural 4-bit lfsr plant, with feedback
//   x^4+x^3+1 (maximal length).
module tb_lfsr_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 5;

  logic          CLK = 1'b0;
  logic          reset, start, mode;
  logic [W-1:0]  seed;
  logic [CW-1:0] steps;

  logic          busy [2], done [2], timeout [2], err_seed [2];
  logic          period_ok [2], sel [2];
  logic [CW-1:0] rcnt [2];
  logic [W-1:0]  a [2];
  logic [W-1:0]  o [2] = '{default: '0};
  logic [W-1:0]  exp_state [2] = '{default: '0};
  int            mx [2] = '{20, 10};

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  lfsr_seq_ctrl #(.WIDTH(W), .CNT_W(CW), .MAX_STEPS(20)) u0 (
    .CLK(CLK), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .steps(steps), .busy(busy[0]), .done(done[0]), .result_cnt(rcnt[0]),
    .timeout(timeout[0]), .err_seed(err_seed[0]), .period_ok(period_ok[0]),
    .lfsr_A(a[0]), .lfsr_select(sel[0]), .lfsr_O(o[0]));

  lfsr_seq_ctrl #(.WIDTH(W), .CNT_W(CW), .MAX_STEPS(10)) u1 (
    .CLK(CLK), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .steps(steps), .busy(busy[1]), .done(done[1]), .result_cnt(rcnt[1]),
    .timeout(timeout[1]), .err_seed(err_seed[1]), .period_ok(period_ok[1]),
    .lfsr_A(a[1]), .lfsr_select(sel[1]), .lfsr_O(o[1]));

  function automatic logic [W-1:0] nxt(input logic [W-1:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  function automatic logic [W-1:0] adv(input logic [W-1:0] v, input int k);
    logic [W-1:0] t = v;
    for (int j = 0; j < k; j++) t = nxt(t);
    return t;
  endfunction

  // lfsr plants
  always @(posedge CLK) begin
    o[0] <= sel[0] ? nxt(o[0]) : a[0];
    o[1] <= sel[1] ? nxt(o[1]) : a[1];
  end

  // Reference model: predicts the run outcome from the seed/mode/steps rules.
  //   lat = index of the edge after which done is seen (accepting edge = 0).
  task automatic model(input logic [W-1:0] s, input bit m, input int n,
                       input int mxs, input logic [W-1:0] prev,
                       output int r, output bit to, output bit er,
                       output logic [W-1:0] fin, output bit pok,
                       output int lat);
    logic [W-1:0] st;
    bit found;
    st = s; found = 0; r = 0; to = 0; er = 0; pok = 0;
    if (s == '0) begin
      er = 1; fin = prev; lat = 0;
      return;
    end
    if (!m) begin
      r = n;
    end else begin
      for (int k = 1; k <= mxs && !found; k++) begin
        st = nxt(st);
        if (st == s) begin r = k; found = 1; end
      end
      if (!found) begin r = mxs; to = 1; end
`ifdef LFSR_SEQ_CTRL_PERIOD_CHECK_EN
      pok = !to && (r == (1 << W) - 1);
`endif
    end
    fin = adv(s, r);
    lat = r + 2;
  endtask

  task automatic check(input string tag, input int i,
                       input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, i, obs, expv);
    end
  endtask

  // One run through both instances.
  //   poke: fire a second start (steps = 7) mid-run; it must be ignored.
  task automatic run(input logic [W-1:0] s, input bit m,
                     input logic [CW-1:0] n, input bit poke);
    int r [2], lat [2], elat [2], shf [2], hld [2], bsy [2];
    bit to [2], er [2], pok [2], seen [2];
    logic [W-1:0] fin [2];
    logic [CW-1:0] rr [2];
    logic tt [2], ee [2], pp [2];
    logic [W-1:0] of [2];

    for (int i = 0; i < 2; i++) begin
      model(s, m, int'(n), mx[i], exp_state[i], r[i], to[i], er[i], fin[i],
            pok[i], elat[i]);
      seen[i] = 0; shf[i] = 0; hld[i] = 0; bsy[i] = 0; lat[i] = -1;
      rr[i] = '0; tt[i] = 0; ee[i] = 0; pp[i] = 0; of[i] = '0;
    end

    @(negedge CLK);
    seed = s; mode = m; steps = n; start = 1'b1;
    for (int e = 0; e < 60 && !(seen[0] && seen[1]); e++) begin
      @(negedge CLK);  // sampled after edge e
      for (int i = 0; i < 2; i++) begin
        if (!seen[i]) begin
          if (sel[i]) shf[i]++;
          if (!sel[i] && a[i] !== o[i]) hld[i]++;
          if (busy[i]) bsy[i]++;
          if (done[i]) begin
            seen[i] = 1; lat[i] = e; rr[i] = rcnt[i]; tt[i] = timeout[i];
            ee[i] = err_seed[i]; pp[i] = period_ok[i]; of[i] = o[i];
          end
        end
      end
      start = 1'b0;
      if (poke && e == 3) begin
        start = 1'b1; steps = 5'd7; mode = ~m; seed = s ^ 4'h5;
      end
    end
    start = 1'b0;

    for (int i = 0; i < 2; i++) begin
      check("done_seen",  i, 32'(seen[i]), 32'd1);
      check("latency",    i, 32'(lat[i]),  32'(elat[i]));
      check("shifts",     i, 32'(shf[i]),  32'(er[i] ? 0 : r[i]));
      check("busy_cyc",   i, 32'(bsy[i]),  32'(elat[i] + 1));
      check("load_cyc",   i, 32'(hld[i]),
            32'((!er[i] && s != exp_state[i]) ? 1 : 0));
      check("result_cnt", i, 32'(rr[i]),   32'(r[i]));
      check("timeout",    i, 32'(tt[i]),   32'(to[i]));
      check("err_seed",   i, 32'(ee[i]),   32'(er[i]));
      check("period_ok",  i, 32'(pp[i]),   32'(pok[i]));
      check("lfsr_fin",   i, 32'(of[i]),   32'(fin[i]));
    end

    // One idle cycle after completion: pulse gone, status and LFSR held.
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      check("done_drop",   i, 32'(done[i]), 32'd0);
      check("busy_drop",   i, 32'(busy[i]), 32'd0);
      check("result_hold", i, 32'(rcnt[i]), 32'(r[i]));
      check("lfsr_hold",   i, 32'(o[i]),    32'(fin[i]));
      exp_state[i] = fin[i];
    end
  endtask

  // Abort a period-mode run with reset while cnt = 5.
  task automatic mid_reset(input logic [W-1:0] s);
    int dn [2] = '{0, 0};
    @(negedge CLK);
    seed = s; mode = 1'b1; steps = '0; start = 1'b1;
    @(negedge CLK);  // after edge 0
    start = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) if (done[i]) dn[i]++;
    end
    reset = 1'b0;    // after edge 6: cnt = 5
    @(negedge CLK);  // after edge 7
    for (int i = 0; i < 2; i++) begin
      if (done[i]) dn[i]++;
      check("rst_nodone",  i, 32'(dn[i]),        32'd0);
      check("rst_busy",    i, 32'(busy[i]),      32'd0);
      check("rst_result",  i, 32'(rcnt[i]),      32'd0);
      check("rst_timeout", i, 32'(timeout[i]),   32'd0);
      check("rst_err",     i, 32'(err_seed[i]),  32'd0);
      check("rst_pok",     i, 32'(period_ok[i]), 32'd0);
      check("rst_lfsr",    i, 32'(o[i]),         32'(adv(s, 5)));
      exp_state[i] = adv(s, 5);
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; steps = '0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy0",   i, 32'(busy[i]),      32'd0);
      check("rst_done0",   i, 32'(done[i]),      32'd0);
      check("rst_result0", i, 32'(rcnt[i]),      32'd0);
      check("rst_flags0",  i, 32'({timeout[i], err_seed[i], period_ok[i]}),
            32'd0);
      check("rst_sel0",    i, 32'(sel[i]),       32'd0);
    end
    reset = 1'b1;

    run(4'hF, 1'b0, 5'd3, 1'b0);   // count run
    run(4'hF, 1'b1, 5'd0, 1'b0);   // period run (u1 times out at 10)
    run(4'h0, 1'b1, 5'd9, 1'b0);   // zero seed
    run(4'hF, 1'b0, 5'd0, 1'b0);   // zero steps
    run(4'h9, 1'b0, 5'd5, 1'b1);   // start during SHIFT ignored
    mid_reset(4'hB);
    run(4'h6, 1'b0, 5'd31, 1'b0);  // longest count run

    for (int t = 0; t < 25; t++) begin
      run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
